// File: rtl/fantasticfft_pkg.sv
// fantasticfft shared types for the 8-point FFT sequencer.
// State encoding, transform size and the bit-reversal helper.
package fantasticfft_pkg;

  localparam int FFT8_N     = 8;
  localparam int FFT8_LOG2N = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_UNLOAD,
    ST_DONE
  } fft8_ctrl_state_t;

  function automatic logic [FFT8_LOG2N-1:0] bitrev3(
    input logic [FFT8_LOG2N-1:0] x
  );
    return {x[0], x[1], x[2]};
  endfunction

endpackage

// File: rtl/fantasticfft_fft8_ctrl_if.sv
// Host handshake and RF/butterfly control bundle of the FFT8 sequencer.
// Optional FANTASTICFFT_FFT8_IFFT_EN adds inverse / tw_conj.
interface fantasticfft_fft8_ctrl_if;

  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       bf_issue;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_idx;
  logic       we_a;
  logic       we_b;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;
`ifdef FANTASTICFFT_FFT8_IFFT_EN
  logic       inverse;
  logic       tw_conj;

  modport master (
    input  start, in_valid, out_ready, inverse,
    output busy, done, in_ready, out_valid, out_idx,
    output bf_issue, rd_addr_a, rd_addr_b, tw_idx,
    output we_a, we_b, wr_addr_a, wr_addr_b, tw_conj
  );

  modport slave (
    output start, in_valid, out_ready, inverse,
    input  busy, done, in_ready, out_valid, out_idx,
    input  bf_issue, rd_addr_a, rd_addr_b, tw_idx,
    input  we_a, we_b, wr_addr_a, wr_addr_b, tw_conj
  );
`else
  modport master (
    input  start, in_valid, out_ready,
    output busy, done, in_ready, out_valid, out_idx,
    output bf_issue, rd_addr_a, rd_addr_b, tw_idx,
    output we_a, we_b, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, in_valid, out_ready,
    input  busy, done, in_ready, out_valid, out_idx,
    input  bf_issue, rd_addr_a, rd_addr_b, tw_idx,
    input  we_a, we_b, wr_addr_a, wr_addr_b
  );
`endif

endinterface

// File: rtl/fantasticfft_fft8_agu.sv
// Butterfly address generator: (stage s, index k) -> a, b, twiddle.
// Purely combinational; only s=0..2 and k=0..3 are meaningful.
module fantasticfft_fft8_agu
  import fantasticfft_pkg::*;
(
  input  logic [1:0]            s_i,
  input  logic [1:0]            k_i,
  output logic [FFT8_LOG2N-1:0] a_o,
  output logic [FFT8_LOG2N-1:0] b_o,
  output logic [1:0]            tw_o
);

  logic [FFT8_LOG2N-1:0] k3;
  logic [FFT8_LOG2N-1:0] span;
  logic [FFT8_LOG2N-1:0] lo;
  logic [FFT8_LOG2N-1:0] hi;

  // group base plus offset inside the group; b is one span above a
  always_comb begin
    k3   = {1'b0, k_i};
    span = 3'b001 << s_i;
    lo   = k3 & (span - 3'd1);
    hi   = (k3 >> s_i) << (s_i + 2'd1);
    a_o  = hi | lo;
    b_o  = a_o + span;
    tw_o = 2'(lo << (2'd2 - s_i));
  end

endmodule

// File: rtl/fantasticfft_fft8_ctrl.sv
// 8-point radix-2 DIT FFT sequencer: load, 3x4 butterflies, unload.
// Optional FANTASTICFFT_FFT8_IFFT_EN adds inverse latch and tw_conj.
module fantasticfft_fft8_ctrl
  import fantasticfft_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  fantasticfft_fft8_ctrl_if.master bus
);

  localparam int L = BF_LAT;
  localparam logic [2:0] LAST = 3'(FFT8_N - 1);
  localparam logic [L-1:0] EARLY = {L{1'b1}} >> 1;

  fft8_ctrl_state_t state_q, state_d;
  logic [2:0] load_q, load_d;
  logic [2:0] unl_q, unl_d;
  logic [1:0] s_q, s_d;
  logic [1:0] k_q, k_d;

  logic [L-1:0]      pv_q, pv_d;
  logic [L-1:0][2:0] pa_q, pa_d;
  logic [L-1:0][2:0] pb_q, pb_d;

  logic [2:0] agu_a, agu_b;
  logic [1:0] agu_tw;
  logic       issue, accept, inflight, wb_v;

  fantasticfft_fft8_agu u_agu (
    .s_i  (s_q),
    .k_i  (k_q),
    .a_o  (agu_a),
    .b_o  (agu_b),
    .tw_o (agu_tw)
  );

  assign issue    = (state_q == ST_ISSUE);
  assign accept   = (state_q == ST_LOAD) && bus.in_valid;
  assign inflight = |(pv_q & EARLY);
  assign wb_v     = pv_q[L-1];

  if (L == 1) begin : g_pipe1
    assign pv_d = issue;
    assign pa_d = agu_a;
    assign pb_d = agu_b;
  end else begin : g_pipen
    assign pv_d = {pv_q[L-2:0], issue};
    assign pa_d = {pa_q[L-2:0], agu_a};
    assign pb_d = {pb_q[L-2:0], agu_b};
  end

  // state and phase counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
      unl_q   <= '0;
      s_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      unl_q   <= unl_d;
      s_q     <= s_d;
      k_q     <= k_d;
    end
  end

  // writeback address pipe, BF_LAT deep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      pa_q <= '0;
      pb_q <= '0;
    end else begin
      pv_q <= pv_d;
      pa_q <= pa_d;
      pb_q <= pb_d;
    end
  end

  // next state and counter updates
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    unl_d   = unl_q;
    s_d     = s_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          load_d = load_q + 3'd1;
          if (load_q == LAST) begin
            state_d = ST_ISSUE;
            s_d     = '0;
            k_d     = '0;
          end
        end
      end
      ST_ISSUE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!inflight) begin
          if (s_q == 2'd2) begin
            state_d = ST_UNLOAD;
            s_d     = '0;
          end else begin
            state_d = ST_ISSUE;
            s_d     = s_q + 2'd1;
          end
        end
      end
      ST_UNLOAD: begin
        if (bus.out_ready) begin
          unl_d = unl_q + 3'd1;
          if (unl_q == LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_UNLOAD);
  assign bus.out_idx   = unl_q;
  assign bus.bf_issue  = issue;
  assign bus.rd_addr_a = issue ? agu_a : '0;
  assign bus.rd_addr_b = issue ? agu_b : '0;
  assign bus.tw_idx    = issue ? agu_tw : '0;
  assign bus.we_a      = accept | wb_v;
  assign bus.we_b      = wb_v;
  assign bus.wr_addr_a = wb_v   ? pa_q[L-1] :
                         accept ? bitrev3(load_q) : '0;
  assign bus.wr_addr_b = wb_v   ? pb_q[L-1] : '0;

`ifdef FANTASTICFFT_FFT8_IFFT_EN
  logic inv_q;

  // direction is captured with the start that launches a transform
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.start) begin
      inv_q <= bus.inverse;
    end
  end

  assign bus.tw_conj = issue & inv_q;
`endif

endmodule

// File: tb/tb_fantasticfft_fft8_ctrl.sv
// Directed bench for the FFT8 sequencer with hand-computed tables.
// Build with FANTASTICFFT_FFT8_IFFT_EN to also cover tw_conj.
module tb_fantasticfft_fft8_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fantasticfft_fft8_ctrl_if bus();

  fantasticfft_fft8_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int exp_wa [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  int cyc = 0;
  int wa_q[$];
  int iss_c[$];
  int iss_v[$];
  int wb_c[$];
  int wb_v[$];
  int hs_q[$];
  int first_unl = -1;
  int done_n = 0;
  int conj_n = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] outs();
    return {bus.busy, bus.done, bus.in_ready, bus.out_valid,
            bus.out_idx, bus.bf_issue, bus.rd_addr_a, bus.rd_addr_b,
            bus.tw_idx, bus.we_a, bus.we_b, bus.wr_addr_a, bus.wr_addr_b};
  endfunction

  always @(negedge clk) begin
    #2;
    cyc++;
    if (bus.we_a && bus.in_ready) wa_q.push_back(int'(bus.wr_addr_a));
    if (bus.bf_issue) begin
      iss_c.push_back(cyc);
      iss_v.push_back({bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx});
`ifdef FANTASTICFFT_FFT8_IFFT_EN
      if (bus.tw_conj) conj_n++;
`endif
    end
    if (bus.we_a && bus.we_b) begin
      wb_c.push_back(cyc);
      wb_v.push_back({bus.wr_addr_a, bus.wr_addr_b});
    end
    if (bus.out_valid && bus.out_ready) hs_q.push_back(int'(bus.out_idx));
    if (bus.out_valid && first_unl < 0) first_unl = cyc;
    if (bus.done) done_n++;
  end

  task automatic clear_logs();
    wa_q.delete();
    iss_c.delete();
    iss_v.delete();
    wb_c.delete();
    wb_v.delete();
    hs_q.delete();
    first_unl = -1;
    done_n = 0;
    conj_n = 0;
  endtask

  // mode 0: plain, 1: gaps and stall, 2: abort by reset in WAIT
  task automatic run_xfer(input int mode, input bit inv);
    int n;
    int t;
    int stall;
    @(negedge clk);
    clear_logs();
    bus.start = 1'b1;
`ifdef FANTASTICFFT_FFT8_IFFT_EN
    bus.inverse = inv;
`endif
    @(negedge clk);
    bus.start = 1'b0;
`ifdef FANTASTICFFT_FFT8_IFFT_EN
    bus.inverse = 1'b0;
`endif
    n = 0;
    t = 0;
    while (n < 8 && t < 64) begin
      bus.in_valid = (mode == 1) ? (t % 2 == 0) : 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) n++;
      @(negedge clk);
      t++;
    end
    bus.in_valid = 1'b0;
    check("load_accepts", n, 8);
    #1;
    check("in_ready_drop", int'(bus.in_ready), 0);
    if (mode == 0) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (mode == 2) begin
      n = 1;
      t = 0;
      while (n < 4 && t < 40) begin
        #1;
        if (bus.bf_issue) n++;
        @(negedge clk);
        t++;
      end
      check("abort_reach_wait", n, 4);
      #1;
      check("wait_writeback", int'(bus.we_a & bus.we_b), 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", int'(outs()), 0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    t = 0;
    #1;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("unload_reached", int'(bus.out_valid), 1);
    n = 0;
    t = 0;
    stall = 0;
    while (n < 8 && t < 64) begin
      if (mode == 1 && n == 4 && stall < 3) begin
        bus.out_ready = 1'b0;
        stall++;
        check("idx_hold", int'(bus.out_idx), 4);
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) n++;
      end
      @(negedge clk);
      #1;
      t++;
    end
    bus.out_ready = 1'b0;
    check("unload_handshakes", n, 8);
    check("done_high", int'({bus.done, bus.busy}), 3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("idle_after_done", int'({bus.done, bus.busy}), 0);
    @(negedge clk);
    #1;
    check("start_in_done_ignored", int'(bus.busy), 0);
    check("done_pulses", done_n, 1);
    check("wa_count", wa_q.size(), 8);
    for (int i = 0; i < wa_q.size() && i < 8; i++)
      check($sformatf("wa%0d", i), wa_q[i], exp_wa[i]);
    check("issue_count", iss_v.size(), 12);
    for (int i = 0; i < iss_v.size() && i < 12; i++)
      check($sformatf("iss%0d", i), iss_v[i],
            exp_a[i] * 32 + exp_b[i] * 4 + exp_tw[i]);
    if (iss_c.size() >= 9) begin
      check("stage1_offset", iss_c[4] - iss_c[0], 6);
      check("stage2_offset", iss_c[8] - iss_c[4], 6);
      check("compute_phase", first_unl - iss_c[0], 18);
    end
    check("wb_count", wb_v.size(), 12);
    for (int i = 0; i < wb_v.size() && i < 12 && i < iss_c.size(); i++) begin
      check($sformatf("wb_lat%0d", i), wb_c[i] - iss_c[i], 2);
      check($sformatf("wb%0d", i), wb_v[i], exp_a[i] * 8 + exp_b[i]);
    end
    check("hs_count", hs_q.size(), 8);
    for (int i = 0; i < hs_q.size() && i < 8; i++)
      check($sformatf("hs%0d", i), hs_q[i], i);
`ifdef FANTASTICFFT_FFT8_IFFT_EN
    check("tw_conj_issues", conj_n, inv ? 12 : 0);
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
`ifdef FANTASTICFFT_FFT8_IFFT_EN
    bus.inverse = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", int'(outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_outs", int'(outs()), 0);
    run_xfer(0, 1'b0);
    run_xfer(1, 1'b1);
    run_xfer(2, 1'b0);
    run_xfer(0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
